// File: rtl/ex_md_stage.sv
// Execute stage: ALU, optional multi-cycle multiply/divide unit with HI/LO, and the E/M register.
// Define MULDIV_EN to build the multiply/divide unit, HI/LO registers and stall generation.
module ex_md_stage #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      instr_in,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      pc4_in,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] imm,
  input  logic             regwrite_in,
  output logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_out,
  output logic [31:0]      instr_out,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc4_out,
  output logic [WIDTH-1:0] rd2_out,
  output logic             regwrite_out,
  output logic             md_busy
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2a;

  logic [5:0]       opcode, funct;
  logic             is_r, is_mult, is_div, is_mthi, is_mtlo;
  logic             accept;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [31:0]      instr_out_q, instr_out_d;
  logic [31:0]      pc_out_q, pc_out_d;
  logic [31:0]      pc4_out_q, pc4_out_d;
  logic [WIDTH-1:0] rd2_out_q, rd2_out_d;
  logic             regwrite_out_q, regwrite_out_d;

  // Instruction class decode
  always_comb begin
    opcode  = instr_in[31:26];
    funct   = instr_in[5:0];
    is_r    = (opcode == OP_RTYPE);
    is_mult = is_r && ((funct == F_MULT) || (funct == F_MULTU));
    is_div  = is_r && ((funct == F_DIV)  || (funct == F_DIVU));
    is_mthi = is_r && (funct == F_MTHI);
    is_mtlo = is_r && (funct == F_MTLO);
  end

`ifdef MULDIV_EN
  localparam int unsigned CW = (MULT_CYCLES > DIV_CYCLES) ? $clog2(MULT_CYCLES + 1)
                                                          : $clog2(DIV_CYCLES + 1);
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {S_IDLE, S_RUN} md_state_e;

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic             md_busy_q, md_busy_d;
  logic             hilo_dep;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;

  assign hilo_dep = is_mult || is_div || is_mthi || is_mtlo ||
                    (is_r && ((funct == F_MFHI) || (funct == F_MFLO)));
  assign stall    = in_valid && md_busy_q && hilo_dep;
  assign md_busy  = md_busy_q;

  // Result is computed from operands sampled at issue; the counter only models latency
  always_comb begin
    if (funct == F_MULT) begin
      prod = {{WIDTH{rd1[WIDTH-1]}}, rd1} * {{WIDTH{rd2[WIDTH-1]}}, rd2};
    end else begin
      prod = {{WIDTH{1'b0}}, rd1} * {{WIDTH{1'b0}}, rd2};
    end
    quo = '1;
    rem = rd1;
    if (rd2 == '0) begin
      quo = '1;
      rem = rd1;
    end else if (funct == F_DIV) begin
      if ((rd1 == SMIN) && (rd2 == '1)) begin
        quo = rd1;
        rem = '0;
      end else begin
        quo = WIDTH'($signed(rd1) / $signed(rd2));
        rem = WIDTH'($signed(rd1) % $signed(rd2));
      end
    end else begin
      quo = rd1 / rd2;
      rem = rd1 % rd2;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept && (is_mult || is_div)) begin
          state_d  = S_RUN;
          cnt_d    = is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          res_hi_d = is_mult ? prod[2*WIDTH-1:WIDTH] : rem;
          res_lo_d = is_mult ? prod[WIDTH-1:0] : quo;
        end else if (accept && is_mthi) begin
          hi_d = rd1;
        end else if (accept && is_mtlo) begin
          lo_d = rd1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    md_busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
      md_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
      md_busy_q <= md_busy_d;
    end
  end
`else
  assign stall   = 1'b0;
  assign md_busy = 1'b0;
`endif

  assign accept = in_valid && !stall;

  // ALU; B is imm for I-type, shifts operate on rd2
  always_comb begin
    alu_res = '0;
    shamt   = SHW'(instr_in[10:6]);
    if (is_r && ((funct == F_SLLV) || (funct == F_SRLV) || (funct == F_SRAV))) begin
      shamt = rd1[SHW-1:0];
    end
    if (is_r) begin
      case (funct)
        F_ADDU:                alu_res = rd1 + rd2;
        F_SUBU:                alu_res = rd1 - rd2;
        F_AND:                 alu_res = rd1 & rd2;
        F_OR:                  alu_res = rd1 | rd2;
        F_SLT:                 alu_res = WIDTH'($signed(rd1) < $signed(rd2));
        F_SLL, F_SLLV:         alu_res = rd2 << shamt;
        F_SRL, F_SRLV:         alu_res = rd2 >> shamt;
        F_SRA, F_SRAV:         alu_res = WIDTH'($signed(rd2) >>> shamt);
`ifdef MULDIV_EN
        F_MFHI:                alu_res = hi_q;
        F_MFLO:                alu_res = lo_q;
`endif
        default:               alu_res = '0;
      endcase
    end else begin
      case (opcode)
        OP_ADDIU, OP_LW, OP_SW: alu_res = rd1 + imm;
        OP_ORI:                 alu_res = rd1 | WIDTH'(imm[15:0]);
        OP_LUI:                 alu_res = WIDTH'({imm[15:0], 16'h0000});
        default:                alu_res = '0;
      endcase
    end
  end

  // E/M register payload; anything not accepted becomes an all-zero bubble
  always_comb begin
    out_valid_d    = 1'b0;
    alu_out_d      = '0;
    instr_out_d    = '0;
    pc_out_d       = '0;
    pc4_out_d      = '0;
    rd2_out_d      = '0;
    regwrite_out_d = 1'b0;
    if (accept) begin
      out_valid_d    = 1'b1;
      alu_out_d      = alu_res;
      instr_out_d    = instr_in;
      pc_out_d       = pc_in;
      pc4_out_d      = pc4_in;
      rd2_out_d      = rd2;
`ifdef MULDIV_EN
      regwrite_out_d = regwrite_in;
`else
      regwrite_out_d = regwrite_in && !(is_mult || is_div || is_mthi || is_mtlo);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      alu_out_q      <= '0;
      instr_out_q    <= '0;
      pc_out_q       <= '0;
      pc4_out_q      <= '0;
      rd2_out_q      <= '0;
      regwrite_out_q <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      alu_out_q      <= alu_out_d;
      instr_out_q    <= instr_out_d;
      pc_out_q       <= pc_out_d;
      pc4_out_q      <= pc4_out_d;
      rd2_out_q      <= rd2_out_d;
      regwrite_out_q <= regwrite_out_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign alu_out      = alu_out_q;
  assign instr_out    = instr_out_q;
  assign pc_out       = pc_out_q;
  assign pc4_out      = pc4_out_q;
  assign rd2_out      = rd2_out_q;
  assign regwrite_out = regwrite_out_q;

endmodule

// File: tb/tb_ex_md_stage.sv
// Self-checking bench for ex_md_stage: random and directed stimulus against a behavioural model.
// Expectations follow MULDIV_EN the same way the design does.
module tb_ex_md_stage;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;
`ifdef MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk, reset, in_valid, regwrite_in;
  logic [31:0] instr_in, pc_in, pc4_in, rd1, rd2, imm;
  logic        stall, out_valid, regwrite_out, md_busy;
  logic [31:0] alu_out, instr_out, pc_out, pc4_out, rd2_out;

  ex_md_stage #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr_in(instr_in),
    .pc_in(pc_in), .pc4_in(pc4_in), .rd1(rd1), .rd2(rd2), .imm(imm),
    .regwrite_in(regwrite_in), .stall(stall), .out_valid(out_valid),
    .alu_out(alu_out), .instr_out(instr_out), .pc_out(pc_out), .pc4_out(pc4_out),
    .rd2_out(rd2_out), .regwrite_out(regwrite_out), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Model state: architectural HI/LO plus a pending result with its completion cycle
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pending;
  int          m_done;

  logic        e_stall, e_busy, e_valid, e_rw, e_pass;
  logic [31:0] e_alu, e_instr, e_pc, e_pc4, e_rd2;
  logic        a_stall, a_busy;

  function automatic logic [31:0] mk_r(input logic [5:0] fn);
    logic [31:0] w;
    w = $urandom;
    w[31:26] = 6'h00;
    w[5:0] = fn;
    return w;
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op);
    logic [31:0] w;
    w = $urandom;
    w[31:26] = op;
    return w;
  endfunction

  function automatic bit is_md_issue(input logic [31:0] ins);
    return (ins[31:26] == 6'h00) && (ins[5:0] >= 6'h18) && (ins[5:0] <= 6'h1b);
  endfunction

  function automatic bit is_hilo(input logic [31:0] ins);
    return is_md_issue(ins) ||
           ((ins[31:26] == 6'h00) && (ins[5:0] >= 6'h10) && (ins[5:0] <= 6'h13));
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] ins, a, b, im, hi, lo);
    logic [5:0] op, fn;
    logic [4:0] sa, sv;
    op = ins[31:26];
    fn = ins[5:0];
    sa = ins[10:6];
    sv = a[4:0];
    if (op == 6'h00) begin
      case (fn)
        6'h00: return b << sa;
        6'h02: return b >> sa;
        6'h03: return $signed(b) >>> sa;
        6'h04: return b << sv;
        6'h06: return b >> sv;
        6'h07: return $signed(b) >>> sv;
        6'h10: return hi;
        6'h12: return lo;
        6'h21: return a + b;
        6'h23: return a - b;
        6'h24: return a & b;
        6'h25: return a | b;
        6'h2a: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: return 32'd0;
      endcase
    end
    case (op)
      6'h09, 6'h23, 6'h2b: return a + im;
      6'h0d: return a | {16'h0000, im[15:0]};
      6'h0f: return {im[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  // Returns {HI, LO}
  function automatic logic [63:0] ref_md(input logic [5:0] fn, input logic [31:0] a, b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (fn)
      6'h18: p = sa * sb;
      6'h19: p = {32'h0, a} * {32'h0, b};
      6'h1a: begin
        if (b == 32'h0) p = {a, 32'hffff_ffff};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) p = {a, 32'hffff_ffff};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
    m_hi = '0; m_lo = '0; m_pending = 0;
  endtask

  // Apply one cycle of input, predict stall/busy and the E/M contents after the edge
  task automatic step(input logic v, input logic [31:0] ins, a, b, im, input logic rw);
    bit acc, md_op;
    logic [63:0] hl;
    in_valid = v; instr_in = ins; rd1 = a; rd2 = b; imm = im; regwrite_in = rw;
    pc_in = $urandom & 32'hffff_fffc;
    pc4_in = pc_in + 32'd4;
    if (m_pending && (cyc > m_done)) begin
      m_hi = m_phi; m_lo = m_plo; m_pending = 0;
    end
    e_busy  = MD && m_pending;
    e_stall = MD && v && e_busy && is_hilo(ins);
    acc     = v && !e_stall;
    md_op   = is_md_issue(ins) || ((ins[31:26] == 6'h00) && (ins[5:0] == 6'h11 || ins[5:0] == 6'h13));
    e_valid = acc;
    e_alu   = acc ? ref_alu(ins, a, b, im, m_hi, m_lo) : 32'h0;
    e_rw    = acc && rw && (MD || !md_op);
    e_instr = acc ? ins : 32'h0;
    e_pc    = acc ? pc_in : 32'h0;
    e_pc4   = acc ? pc4_in : 32'h0;
    e_rd2   = acc ? b : 32'h0;
    e_pass  = !acc || MD || !md_op;
    if (acc && MD) begin
      if (is_md_issue(ins)) begin
        hl = ref_md(ins[5:0], a, b);
        m_phi = hl[63:32]; m_plo = hl[31:0];
        m_pending = 1;
        m_done = cyc + ((ins[5:0] <= 6'h19) ? MC : DC);
      end else if (ins[31:26] == 6'h00 && ins[5:0] == 6'h11) m_hi = a;
      else if (ins[31:26] == 6'h00 && ins[5:0] == 6'h13) m_lo = a;
    end
    @(negedge clk);
    a_stall = stall;
    a_busy = md_busy;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Issue an mfhi/mflo and hold it until accepted; returns the number of stalled cycles
  task automatic wait_read(input logic [5:0] fn, output int stalls);
    logic [31:0] ins;
    ins = mk_r(fn);
    stalls = 0;
    step(1'b1, ins, $urandom, $urandom, 32'h0, 1'b1);
    while (a_stall === 1'b1 && stalls < 40) begin
      stalls++;
      step(1'b1, ins, $urandom, $urandom, 32'h0, 1'b1);
    end
    if (stalls >= 40) begin
      n_vec++; n_err++;
      $display("FAIL read_timeout fn=%h stalled %0d cycles", fn, stalls);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({out_valid, regwrite_out, md_busy, alu_out, instr_out, pc_out, pc4_out, rd2_out} !== '0) begin
      n_err++;
      $display("FAIL reset_state valid=%b rw=%b busy=%b alu=%h instr=%h got nonzero, want all 0",
               out_valid, regwrite_out, md_busy, alu_out, instr_out);
    end
  endtask

  task automatic test_addu();
    step(1'b1, mk_r(6'h21), 32'hffff_ffff, 32'h2, 32'h0, 1'b1);
    n_vec++;
    if ({out_valid, regwrite_out, alu_out} !== {1'b1, 1'b1, 32'h1} || rd2_out !== 32'h2) begin
      n_err++;
      $display("FAIL addu_wrap valid=%b rw=%b alu=%h rd2=%h want 1 1 00000001 00000002",
               out_valid, regwrite_out, alu_out, rd2_out);
    end
    step(1'b0, mk_r(6'h21), 32'h5, 32'h6, 32'h0, 1'b1);
    n_vec++;
    if ({out_valid, regwrite_out, alu_out, instr_out} !== '0) begin
      n_err++;
      $display("FAIL bubble valid=%b rw=%b alu=%h want 0 0 0", out_valid, regwrite_out, alu_out);
    end
  endtask

  task automatic test_mult_mfhi();
    int st;
    step(1'b1, mk_r(6'h18), 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0);
    wait_read(6'h10, st);
    n_vec++;
    if (st != (MD ? MC : 0)) begin
      n_err++;
      $display("FAIL mult_stall_len got %0d want %0d", st, MD ? MC : 0);
    end
    n_vec++;
    if (alu_out !== (MD ? 32'h1 : 32'h0) || alu_out !== e_alu || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mult_mfhi alu=%h valid=%b want %h 1", alu_out, out_valid, e_alu);
    end
    wait_read(6'h12, st);
    n_vec++;
    if (alu_out !== 32'h0 || st != 0) begin
      n_err++;
      $display("FAIL mult_mflo alu=%h stalls=%0d want 0 0", alu_out, st);
    end
  endtask

  task automatic test_divide();
    int st;
    logic [31:0] want_lo [5] = '{32'hffff_fffd, 32'h3, 32'hffff_ffff, 32'h8000_0000, 32'hffff_ffff};
    logic [31:0] want_hi [5] = '{32'hffff_ffff, 32'h1, 32'h0000_1234, 32'h0, 32'hffff_fff9};
    logic [5:0]  fns [5] = '{6'h1a, 6'h1b, 6'h1b, 6'h1a, 6'h1a};
    logic [31:0] as [5] = '{32'hffff_fff9, 32'h7, 32'h1234, 32'h8000_0000, 32'hffff_fff9};
    logic [31:0] bs [5] = '{32'h2, 32'h2, 32'h0, 32'hffff_ffff, 32'h0};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, mk_r(fns[i]), as[i], bs[i], 32'h0, 1'b0);
      wait_read(6'h12, st);
      n_vec++;
      if (alu_out !== (MD ? want_lo[i] : 32'h0) || alu_out !== e_alu || st != (MD ? DC : 0)) begin
        n_err++;
        $display("FAIL div_lo case=%0d alu=%h stalls=%0d want %h %0d", i, alu_out, st, e_alu, MD ? DC : 0);
      end
      wait_read(6'h10, st);
      n_vec++;
      if (alu_out !== (MD ? want_hi[i] : 32'h0) || alu_out !== e_alu) begin
        n_err++;
        $display("FAIL div_hi case=%0d alu=%h want %h", i, alu_out, e_alu);
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    int st;
    logic [31:0] h, l;
    h = $urandom; l = $urandom;
    step(1'b1, mk_r(6'h11), h, 32'h0, 32'h0, 1'b0);
    step(1'b1, mk_r(6'h13), l, 32'h0, 32'h0, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || regwrite_out !== e_rw || alu_out !== 32'h0) begin
      n_err++;
      $display("FAIL mtlo_slot valid=%b rw=%b alu=%h want 1 %b 0", out_valid, regwrite_out, alu_out, e_rw);
    end
    wait_read(6'h10, st);
    n_vec++;
    if (alu_out !== (MD ? h : 32'h0)) begin
      n_err++;
      $display("FAIL mthi_read alu=%h want %h", alu_out, MD ? h : 32'h0);
    end
    wait_read(6'h12, st);
    n_vec++;
    if (alu_out !== (MD ? l : 32'h0)) begin
      n_err++;
      $display("FAIL mtlo_read alu=%h want %h", alu_out, MD ? l : 32'h0);
    end
  endtask

  task automatic test_back_to_back_reset();
    int st;
    bit busy_bad;
    step(1'b1, mk_r(6'h1a), 32'd100, 32'd7, 32'h0, 1'b0);
    step(1'b1, mk_r(6'h21), 32'd5, 32'd6, 32'h0, 1'b1);
    n_vec++;
    if (a_stall !== 1'b0 || a_busy !== MD || alu_out !== 32'd11 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL addu_during_run stall=%b busy=%b alu=%h valid=%b want 0 %b 0000000b 1",
               a_stall, a_busy, alu_out, out_valid, MD);
    end
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    do_reset();
    n_vec++;
    if (md_busy !== 1'b0 || out_valid !== 1'b0 || alu_out !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid_run busy=%b valid=%b alu=%h want 0 0 0", md_busy, out_valid, alu_out);
    end
    busy_bad = 0;
    for (int i = 0; i < DC + 2; i++) begin
      step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      if (a_busy !== 1'b0) busy_bad = 1;
    end
    n_vec++;
    if (busy_bad) begin
      n_err++;
      $display("FAIL aborted_busy md_busy seen 1 want 0 after reset");
    end
    wait_read(6'h12, st);
    n_vec++;
    if (alu_out !== 32'h0 || st != 0) begin
      n_err++;
      $display("FAIL aborted_lo alu=%h stalls=%0d want 0 0", alu_out, st);
    end
  endtask

  task automatic test_random();
    logic [5:0] rfn [20] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23, 6'h24, 6'h25,
                             6'h2a, 6'h10, 6'h12, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h20};
    logic [5:0] iop [6] = '{6'h09, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h08};
    logic [31:0] ins, a, b, im;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) ins = mk_i(iop[$urandom_range(0, 5)]);
      else ins = mk_r(rfn[$urandom_range(0, 19)]);
      a = $urandom; b = $urandom; im = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hffff_ffff;
        2: a = 32'h8000_0000;
        default: ;
      endcase
      step($urandom_range(0, 7) != 0, ins, a, b, im, 1'($urandom));
      n_vec++;
      if (a_stall !== e_stall || a_busy !== e_busy) begin
        n_err++;
        $display("FAIL rand_ctl cyc=%0d stall=%b want %b busy=%b want %b", cyc, a_stall, e_stall, a_busy, e_busy);
      end
      n_vec++;
      if ({out_valid, regwrite_out, alu_out} !== {e_valid, e_rw, e_alu}) begin
        n_err++;
        $display("FAIL rand_result cyc=%0d ins=%h valid=%b rw=%b alu=%h want %b %b %h",
                 cyc, ins, out_valid, regwrite_out, alu_out, e_valid, e_rw, e_alu);
      end
      if (e_pass) begin
        n_vec++;
        if ({instr_out, pc_out, pc4_out, rd2_out} !== {e_instr, e_pc, e_pc4, e_rd2}) begin
          n_err++;
          $display("FAIL rand_pass cyc=%0d instr=%h pc=%h pc4=%h rd2=%h want %h %h %h %h",
                   cyc, instr_out, pc_out, pc4_out, rd2_out, e_instr, e_pc, e_pc4, e_rd2);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; instr_in = '0; pc_in = '0; pc4_in = '0;
    rd1 = '0; rd2 = '0; imm = '0; regwrite_in = 1'b0;
    m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_pending = 0; m_done = 0;
    test_reset();
    test_addu();
    test_mult_mfhi();
    test_divide();
    test_mthi_mtlo();
    test_back_to_back_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_md_stage.md
# ex_md_stage

Parametrised execute stage for the five-stage MIPS pipeline. It sits between decode and memory and performs the following:
- ALU operations;
- a multi-cycle multiply/divide unit with HI/LO registers;
- a registered hand-off (the E/M pipeline register) to the memory stage.

Unlike the original purely combinational execute stage, it owns state: the E/M register, the HI/LO registers and a busy counter. It produces a stall request while a HI/LO-dependent instruction must wait.

## Interface
Parameters:
- WIDTH, 32: datapath width for operands, results, HI and LO.
- MULT_CYCLES, 5: cycles from mult/multu issue to HI/LO valid (≥1).
- DIV_CYCLES, 10: cycles from div/divu issue to HI/LO valid (≥1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decode presents a valid instruction.
- instr_in  in  32  instruction word.
- pc_in, pc4_in  in  32  PC and PC+4 of the instruction.
- rd1, rd2  in  WIDTH  forwarded register operands.
- imm  in  WIDTH  extended immediate.
- regwrite_in  in  1  decode's register-write enable.
- stall  out  1  combinational; decode and fetch must hold while high.
- out_valid  out  1  registered; E/M slot holds a real instruction.
- alu_out  out  WIDTH  registered result: ALU result, HI or LO.
- instr_out, pc_out, pc4_out  out  32  registered copies of the inputs.
- rd2_out  out  WIDTH  registered store data.
- regwrite_out  out  1  registered; forced to 0 whenever out_valid is 0.
- md_busy  out  1  registered; multiply/divide unit is in progress.

## Operation
- ALU operations, with B selected as imm for I-type:
  - addu/addiu/lw/sw: A+B, wrap mod 2^WIDTH.
  - subu: A−B, wrap mod 2^WIDTH.
  - and, or, ori (zero-extended imm).
  - slt (signed compare).
  - lui: imm[15:0] followed by 16 zeros, truncated to WIDTH.
  - sll/srl/sra: shift amount is instr[10:6], or rd1 low bits for sllv/srlv/srav; only the low $clog2(WIDTH) bits are used.
  - Any other opcode: alu_out = 0, passed through.
- Multiply/divide state machine with states IDLE and RUN.
  - Issue of mult/multu/div/divu in IDLE moves to RUN and loads the counter with MULT_CYCLES or DIV_CYCLES.
  - The counter decrements each cycle. When it reaches 0, HI/LO are written and the state returns to IDLE.
- Result rules:
  - mult/multu: {HI,LO} = full 2·WIDTH-bit signed or unsigned product.
  - div/divu: LO = quotient, truncated toward zero; HI = remainder, carrying the dividend's sign.
  - Divide by zero: LO = all ones, HI = dividend.
  - Signed overflow (−2^(WIDTH−1) / −1): LO = dividend, HI = 0.
- mfhi/mflo place HI/LO on alu_out.
- mthi/mtlo write rd1 into HI/LO at the end of the cycle in which the instruction is accepted.
- HI/LO-dependent instructions are mult/multu/div/divu, mfhi/mflo and mthi/mtlo.
  - stall = in_valid & md_busy & (instruction is HI/LO-dependent).
  - While stall is high, the E/M register loads a bubble: out_valid=0, regwrite_out=0, other fields 0. The unit state is not disturbed.

## Timing
- Accepted instruction to E/M register: 1 cycle latency.
- Operands are sampled at issue; later changes on rd1/rd2 have no effect.
- mult issued at cycle t:
  - md_busy is high during cycles t+1 … t+MULT_CYCLES.
  - HI/LO are valid from t+MULT_CYCLES+1.
  - An mfhi arriving at t+1 stalls MULT_CYCLES cycles, then is accepted.
- Non-HI/LO instructions proceed during RUN without stalling.
- mfhi in the same cycle that the counter hits 0 still stalls one cycle, because md_busy is registered.
- Reset, including mid-RUN:
  - state=IDLE, counter=0, HI=LO=0, md_busy=0.
  - out_valid=0, regwrite_out=0, and all data outputs 0.
  - The aborted result is discarded.
- in_valid=0 loads a bubble.

## Configuration
- MULDIV_EN defined: the multiply/divide unit, HI/LO and stall generation are compiled in, as described above.
- MULDIV_EN undefined: no HI/LO or counter state exists.
  - md_busy and stall are tied to 0.
  - mult/div/mthi/mtlo behave as bubbles, with regwrite_out=0 but out_valid=1.
  - mfhi/mflo return 0.

## Test plan
- Reset, then addu with rd1=0xFFFFFFFF and rd2=2 → next cycle alu_out=0x00000001, out_valid=1, regwrite_out=1.
- mult with rd1=rd2=0x00010000, then mfhi → stall high for 5 cycles; mfhi result alu_out=0x00000001; a later mflo returns 0.
- div with rd1=0xFFFFFFF9 (−7) and rd2=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with rd1=7 and rd2=2 → LO=3, HI=1.
- divu with rd2=0 and rd1=0x1234 → LO=0xFFFFFFFF, HI=0x00001234.
- div issued, addu at t+1 proceeds with no stall, reset asserted at t+4 → md_busy=0 next cycle; mflo returns 0.
- With MULDIV_EN undefined, mult followed by mfhi → stall never asserted; mfhi alu_out=0.
